// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = (a - b - bin) mod 2^N, one bit per clock, LSB first; optional ovf via SERIAL_SUB_OVF_EN.
// Latency: N cycles from the accepting edge to done; one operation per N+2 cycles.
// Backpressure: start is honoured only while ready=1 (IDLE); requests at other times are dropped, not queued.
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (N < 1) ? 1 : $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic [N-1:0]   work;
    logic [CW-1:0]  cnt;
    logic           brw;

    logic           a_i;
    logic           b_i;
    logic           d_i;
    logic           brw_nxt;
    logic [N:0]     work_ext;
    logic [N-1:0]   work_nxt;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept aside because the shift registers lose them during RUN.
    logic           a_msb;
    logic           b_msb;
`endif

    // Full-subtractor cell on the current LSBs plus the next working-register value.
    always_comb begin
        a_i      = a_sh[0];
        b_i      = b_sh[0];
        d_i      = a_i ^ b_i ^ brw;
        brw_nxt  = (~a_i & b_i) | (~(a_i ^ b_i) & brw);
        work_ext = {d_i, work};
        work_nxt = work_ext[N:1];
    end

    // Control FSM with datapath; results are published only on the final RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            work  <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= bin;
                        work  <= '0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[N-1];
                        b_msb <= b[N-1];
`endif
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    brw  <= brw_nxt;
                    work <= work_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff  <= work_nxt;
                        bout  <= brw_nxt;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // d_i is the result MSB on this edge.
                        ovf   <= (a_msb != b_msb) && (d_i != a_msb);
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
